// File: rtl/branch_decoder.sv
// branch_decoder: buffers {code, len} pairs in a FIFO and replays each as a
// registered (b, c, d) pattern with one-hot select, held for len+1 cycles.
module branch_decoder #(
  parameter int DEPTH = 4,
  parameter int LEN_W = 4
) (
  input  logic                      _clock,
  input  logic                      _reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [1:0]                in_code,
  input  logic [LEN_W-1:0]          in_len,
  output logic                      out_active,
  output logic [3:0]                out_sel,
  output logic                      out_b,
  output logic                      out_c,
  output logic [1:0]                out_d,
  output logic                      out_done,
  output logic [$clog2(DEPTH):0]    fifo_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [LEN_W+1:0] mem [DEPTH];
  logic [AW-1:0]    wp, rp;
  logic [CW-1:0]    cnt;
  logic [0:0]       state;
  logic [LEN_W-1:0] hold;
  logic             push, pop;
  logic [1:0]       hcode;
  logic [LEN_W-1:0] hlen;

  assign in_ready   = cnt != CW'(DEPTH);
  assign fifo_count = cnt;
  assign push       = in_valid && in_ready;
  assign {hcode, hlen} = mem[rp];
  // Reload on the last held cycle so back-to-back codes leave no bubble.
  assign pop        = cnt != '0 && (state == IDLE || hold == '0);
  assign out_active = state;

  always_ff @(posedge _clock)
    if (push) mem[wp] <= {in_code, in_len};

  always_ff @(posedge _clock or negedge _reset)
    if (!_reset) begin
      wp       <= '0;
      rp       <= '0;
      cnt      <= '0;
      state    <= IDLE;
      hold     <= '0;
      out_sel  <= '0;
      out_b    <= 1'b0;
      out_c    <= 1'b0;
      out_d    <= '0;
      out_done <= 1'b0;
    end else begin
      wp  <= wp + AW'(push);
      rp  <= rp + AW'(pop);
      cnt <= cnt + CW'(push) - CW'(pop);
      if (pop) begin
        state    <= HOLD;
        hold     <= hlen;
        out_sel  <= 4'b0001 << hcode;
        out_b    <= !hcode[0];
        out_c    <= hcode == 2'd1;
        out_d    <= {2{&hcode}};
        out_done <= hlen == '0;
      end else if (state == HOLD && hold != '0) begin
        hold     <= hold - 1'b1;
        out_done <= hold == LEN_W'(1);
      end else begin
        state    <= IDLE;
        hold     <= '0;
        out_sel  <= '0;
        out_b    <= 1'b0;
        out_c    <= 1'b0;
        out_d    <= '0;
        out_done <= 1'b0;
      end
    end
endmodule

// File: tb/tb_branch_decoder.sv
// tb_branch_decoder: random and directed stimulus checked every cycle against
// a queue-based model, plus literal expectations for the directed scenarios.
module tb_branch_decoder;
  localparam int DEPTH = 4;
  localparam int LEN_W = 4;
  localparam logic [3:0] BCD [4] = '{4'b1000, 4'b0100, 4'b1000, 4'b0011};

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic in_valid = 1'b0;
  logic [1:0] in_code = '0;
  logic [LEN_W-1:0] in_len = '0;
  logic in_ready, out_active, out_b, out_c, out_done;
  logic [3:0] out_sel;
  logic [1:0] out_d;
  logic [2:0] fifo_count;

  branch_decoder #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    ._clock(clk), ._reset(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_code(in_code), .in_len(in_len), .out_active(out_active),
    .out_sel(out_sel), .out_b(out_b), .out_c(out_c), .out_d(out_d),
    .out_done(out_done), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: pending entries in a queue; the replaying code and cycles it has left.
  logic [5:0] q [$];
  bit m_act = 0;
  logic [1:0] m_code = '0;
  int m_rem = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_act = 0;
      m_rem = 0;
    end else begin
      bit pu, po;
      logic [5:0] it;
      pu = in_valid && q.size() != DEPTH;
      po = (!m_act || m_rem == 1) && q.size() != 0;
      if (po) begin
        it = q.pop_front();
        m_act = 1;
        m_code = it[5:4];
        m_rem = int'(it[3:0]) + 1;
      end else if (m_act) begin
        if (m_rem == 1) m_act = 0;
        else m_rem--;
      end
      if (pu) q.push_back({in_code, in_len});
    end
  end

  function automatic logic [13:0] model_out();
    logic [3:0] bcd;
    logic [3:0] sel;
    bcd = m_act ? BCD[m_code] : 4'b0;
    sel = m_act ? 4'(1 << m_code) : 4'b0;
    return {q.size() != DEPTH, 3'(q.size()), m_act, sel, bcd, m_act && m_rem == 1};
  endfunction

  always @(negedge clk) begin
    logic [13:0] got, exp;
    got = {in_ready, fifo_count, out_active, out_sel, out_b, out_c, out_d, out_done};
    exp = model_out();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL cycle_model t=%0t got=%b expected=%b", $time, got, exp);
    end
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", nm, $time, act, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic push(input logic [1:0] c, input logic [3:0] l);
    int n = 0;
    in_valid = 1'b1;
    in_code = c;
    in_len = l;
    while (q.size() == DEPTH && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("push_timeout", 16'(n), 16'd0);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q.size() != 0 || m_act) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("idle_timeout", 16'(n), 16'd0);
    @(negedge clk);
  endtask

  initial begin
    logic [1:0] pat [4];
    int n;
    pat = '{2'd1, 2'd3, 2'd0, 2'd2};
    #1 rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_outputs", {out_active, out_sel, out_b, out_c, out_d, out_done}, 16'd0);
      chk("rst_ready_count", {in_ready, fifo_count}, 16'b1000);
    end
    rst_n = 1'b1;

    push(2'd3, 4'd2);
    chk("single_count", fifo_count, 16'd1);
    chk("single_not_yet", out_active, 16'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("single_hold", {out_active, out_sel, out_b, out_c, out_d, out_done},
          {7'b0, 1'b1, 4'b1000, 1'b0, 1'b0, 2'd3, 1'(i == 2)});
    end
    @(negedge clk);
    chk("single_end", {out_active, out_sel, out_b, out_c, out_d, out_done}, 16'd0);
    wait_idle();

    fork
      begin
        push(2'd0, 4'd0);
        push(2'd1, 4'd0);
        push(2'd2, 4'd0);
        push(2'd3, 4'd0);
      end
      begin
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          chk("table_bcd_done", {out_b, out_c, out_d, out_done}, {11'b0, BCD[i], 1'b1});
          chk("table_sel", out_sel, 16'(1 << i));
        end
      end
    join
    wait_idle();

    push(2'd0, 4'd15);
    push(2'd1, 4'd1);
    push(2'd2, 4'd2);
    push(2'd3, 4'd3);
    push(2'd1, 4'd0);
    chk("full_count", {in_ready, fifo_count}, 16'b0100);
    in_valid = 1'b1;
    in_code = 2'd2;
    in_len = 4'd5;
    repeat (3) begin
      @(negedge clk);
      chk("full_no_accept", {in_ready, fifo_count}, 16'b0100);
    end
    push(2'd2, 4'd5);
    wait_idle();

    for (int i = 0; i < 10; i++) begin
      n = $urandom_range(0, 2);
      repeat (n) @(negedge clk);
      push(pat[i % 4], 4'($urandom_range(0, 3)));
    end
    for (int i = 0; i < 40; i++) begin
      n = $urandom_range(0, 3);
      repeat (n) @(negedge clk);
      push(2'($urandom), 4'($urandom_range(0, 5)));
    end
    wait_idle();

    push(2'd1, 4'd7);
    push(2'd2, 4'd1);
    push(2'd3, 4'd2);
    @(negedge clk);
    chk("pre_reset_active", {out_active, out_sel, out_c, fifo_count}, {7'b0, 1'b1, 4'b0010, 1'b1, 3'd2});
    #2 rst_n = 1'b0;
    #1;
    chk("async_clear", {out_active, out_sel, out_b, out_c, out_d, out_done}, 16'd0);
    chk("async_fifo", {in_ready, fifo_count}, 16'b1000);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("post_reset_idle", {out_active, fifo_count}, 16'd0);
    end

    push(2'd2, 4'd3);
    n = 0;
    while (!(m_act && m_rem == 2) && n < 50) begin
      @(negedge clk);
      n++;
    end
    push(2'd1, 4'd0);
    chk("edge_done", {out_done, out_sel, fifo_count}, {8'b0, 1'b1, 4'b0100, 3'd1});
    @(negedge clk);
    chk("edge_next", {out_active, out_sel, out_c, out_done}, {9'b0, 1'b1, 4'b0010, 1'b1, 1'b1});
    @(negedge clk);
    chk("edge_idle", {out_active, out_sel, out_done}, 16'd0);
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
